// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard control bundle: ID/EX hazard inputs, branch resolve, counter clear,
// plus the pipeline register controls and statistics driven back.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             mem_branch_taken;
  logic             cnt_clr;
  logic             pc_write;
  logic             pc_sel_branch;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             ex_mem_flush;
  logic             busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt,
    output ex_mem_read, ex_rt,
    output mem_branch_taken, cnt_clr,
    input  pc_write, pc_sel_branch,
    input  if_id_write, if_id_flush,
    input  id_ex_bubble, ex_mem_flush,
    input  busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt,
    input  ex_mem_read, ex_rt,
    input  mem_branch_taken, cnt_clr,
    output pc_write, pc_sel_branch,
    output if_id_write, if_id_flush,
    output id_ex_bubble, ex_mem_flush,
    output busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall / branch flush control with saturating event counters.
// Ports: clk, rst (sync, active-high), bus (slave side of pipe_hazard_ctrl_if).
module pipe_hazard_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input logic                 clk,
  input logic                 rst,
  pipe_hazard_ctrl_if.slave   bus
);

  typedef enum logic {
    RUN,
    STALL
  } state_t;

  // STALL is entered after the first stall cycle spent in RUN,
  // so the counter covers the remaining STALL_CYCLES-1 cycles.
  localparam logic [3:0] REM_INIT =
    (STALL_CYCLES > 1) ? 4'(STALL_CYCLES - 2) : 4'd0;
  localparam logic [CNT_W-1:0] ONE = 1;

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       rem_q;
  logic [3:0]       rem_d;
  logic             hazard;
  logic             do_stall;
  logic             do_flush;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // $0 is hardwired zero, so a load into it never creates a dependency.
  assign hazard = bus.id_valid
                & bus.ex_mem_read
                & (bus.ex_rt != 5'd0)
                & ((bus.ex_rt == bus.id_rs)
                 | (bus.id_uses_rt
                  & (bus.ex_rt == bus.id_rt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      rem_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    do_stall = 1'b0;
    do_flush = 1'b0;
    if (rst) begin
      state_d = RUN;
      rem_d   = 4'd0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.mem_branch_taken) begin
            do_flush = 1'b1;
          end else if (hazard) begin
            do_stall = 1'b1;
            if (STALL_CYCLES > 1) begin
              state_d = STALL;
              rem_d   = REM_INIT;
            end
          end
        end
        STALL: begin
          if (bus.mem_branch_taken) begin
            do_flush = 1'b1;
            state_d  = RUN;
            rem_d    = 4'd0;
          end else begin
            do_stall = 1'b1;
            if (rem_q == 4'd0) begin
              state_d = RUN;
            end else begin
              rem_d = rem_q - 4'd1;
            end
          end
        end
      endcase
    end
  end

  // rst, do_flush and do_stall are mutually exclusive by construction.
  always_comb begin
    bus.pc_write      = 1'b1;
    bus.pc_sel_branch = 1'b0;
    bus.if_id_write   = 1'b1;
    bus.if_id_flush   = 1'b0;
    bus.id_ex_bubble  = 1'b0;
    bus.ex_mem_flush  = 1'b0;
    unique case (1'b1)
      rst: begin
        bus.pc_write     = 1'b0;
        bus.if_id_write  = 1'b0;
        bus.if_id_flush  = 1'b1;
        bus.id_ex_bubble = 1'b1;
        bus.ex_mem_flush = 1'b1;
      end
      do_flush: begin
        bus.pc_sel_branch = 1'b1;
        bus.if_id_flush   = 1'b1;
        bus.id_ex_bubble  = 1'b1;
        bus.ex_mem_flush  = 1'b1;
      end
      do_stall: begin
        bus.pc_write     = 1'b0;
        bus.if_id_write  = 1'b0;
        bus.id_ex_bubble = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.busy = (state_q == STALL) & ~rst;

  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (do_stall && (stall_q != '1)) begin
        stall_q <= stall_q + ONE;
      end
      if (do_flush && (flush_q != '1)) begin
        flush_q <= flush_q + ONE;
      end
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: three configurations share one random stimulus stream;
// a reference model pushes expectations, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [6:0]  ctl;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_uses_rt = 1'b0;
  logic       ex_mem_read = 1'b0;
  logic [4:0] ex_rt = '0;
  logic       br = 1'b0;
  logic       cnt_clr = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(16)) if0 ();
  pipe_hazard_ctrl_if #(.CNT_W(16)) if1 ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  if2 ();

  pipe_hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave));
  pipe_hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave));
  pipe_hazard_ctrl #(.STALL_CYCLES(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave));

  assign if0.id_valid = id_valid;
  assign if0.id_rs = id_rs;
  assign if0.id_rt = id_rt;
  assign if0.id_uses_rt = id_uses_rt;
  assign if0.ex_mem_read = ex_mem_read;
  assign if0.ex_rt = ex_rt;
  assign if0.mem_branch_taken = br;
  assign if0.cnt_clr = cnt_clr;
  assign if1.id_valid = id_valid;
  assign if1.id_rs = id_rs;
  assign if1.id_rt = id_rt;
  assign if1.id_uses_rt = id_uses_rt;
  assign if1.ex_mem_read = ex_mem_read;
  assign if1.ex_rt = ex_rt;
  assign if1.mem_branch_taken = br;
  assign if1.cnt_clr = cnt_clr;
  assign if2.id_valid = id_valid;
  assign if2.id_rs = id_rs;
  assign if2.id_rt = id_rt;
  assign if2.id_uses_rt = id_uses_rt;
  assign if2.ex_mem_read = ex_mem_read;
  assign if2.ex_rt = ex_rt;
  assign if2.mem_branch_taken = br;
  assign if2.cnt_clr = cnt_clr;

  exp_t act0, act1, act2;
  assign act0 = {if0.pc_write, if0.pc_sel_branch, if0.if_id_write,
                 if0.if_id_flush, if0.id_ex_bubble, if0.ex_mem_flush,
                 if0.busy, 16'(if0.stall_cnt), 16'(if0.flush_cnt)};
  assign act1 = {if1.pc_write, if1.pc_sel_branch, if1.if_id_write,
                 if1.if_id_flush, if1.id_ex_bubble, if1.ex_mem_flush,
                 if1.busy, 16'(if1.stall_cnt), 16'(if1.flush_cnt)};
  assign act2 = {if2.pc_write, if2.pc_sel_branch, if2.if_id_write,
                 if2.if_id_flush, if2.id_ex_bubble, if2.ex_mem_flush,
                 if2.busy, 16'(if2.stall_cnt), 16'(if2.flush_cnt)};

  int sc_p[3]  = '{1, 3, 2};
  int max_p[3] = '{65535, 65535, 15};
  int m_left[3] = '{0, 0, 0};
  int m_sc[3]   = '{0, 0, 0};
  int m_fc[3]   = '{0, 0, 0};

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  // Reference: a stall is "remaining stall cycles"; outputs follow the
  // rst > branch > (ongoing stall or new hazard) > idle priority.
  task automatic model_step();
    bit hz;
    hz = id_valid && ex_mem_read && (ex_rt != 0)
      && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      bit stall;
      bit flush;
      bit busy;
      stall = 0;
      flush = 0;
      busy = (m_left[i] > 0) && !rst;
      e.sc = 16'(m_sc[i]);
      e.fc = 16'(m_fc[i]);
      if (rst) begin
        e.ctl = 7'b0001110;
      end else begin
        if (br) flush = 1;
        else if (m_left[i] > 0 || hz) stall = 1;
        if (flush) e.ctl = {6'b111111, busy};
        else if (stall) e.ctl = {6'b000010, busy};
        else e.ctl = {6'b101000, busy};
      end
      case (i)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
      if (rst) begin
        m_left[i] = 0;
        m_sc[i] = 0;
        m_fc[i] = 0;
      end else begin
        if (flush) m_left[i] = 0;
        else if (stall)
          m_left[i] = (m_left[i] > 0) ? m_left[i] - 1 : sc_p[i] - 1;
        if (cnt_clr) begin
          m_sc[i] = 0;
          m_fc[i] = 0;
        end else begin
          if (stall && m_sc[i] < max_p[i]) m_sc[i]++;
          if (flush && m_fc[i] < max_p[i]) m_fc[i]++;
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic v,
                     input int rs, input int rt, input logic urt,
                     input logic mr, input int ert,
                     input logic b, input logic c);
    @(posedge clk);
    #1;
    rst = r;
    id_valid = v;
    id_rs = 5'(rs);
    id_rt = 5'(rt);
    id_uses_rt = urt;
    ex_mem_read = mr;
    ex_rt = 5'(ert);
    br = b;
    cnt_clr = c;
    model_step();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cmp(input int i, input exp_t e, input exp_t a);
    checks++;
    if (a.ctl !== e.ctl) begin
      errors++;
      $display("FAIL ctl dut%0d t=%0t: got %b expected %b",
               i, $time, a.ctl, e.ctl);
    end
    checks++;
    if (a.sc !== e.sc) begin
      errors++;
      $display("FAIL stall_cnt dut%0d t=%0t: got %0d expected %0d",
               i, $time, a.sc, e.sc);
    end
    checks++;
    if (a.fc !== e.fc) begin
      errors++;
      $display("FAIL flush_cnt dut%0d t=%0t: got %0d expected %0d",
               i, $time, a.fc, e.fc);
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q0.size() > 0) cmp(0, q0.pop_front(), act0);
      if (q1.size() > 0) cmp(1, q1.pop_front(), act1);
      if (q2.size() > 0) cmp(2, q2.pop_front(), act2);
    end
  end

  initial begin
    // reset held with branch and hazard present
    cyc(1, 1, 8, 0, 0, 1, 8, 1, 0);
    cyc(1, 1, 8, 0, 0, 1, 8, 1, 0);
    @(negedge clk);
    chk("rst_pc_write", int'(if0.pc_write), 0);
    chk("rst_sel_branch", int'(if1.pc_sel_branch), 0);
    chk("rst_stall_cnt", int'(if1.stall_cnt), 0);
    idle(1);
    // load-use on rs, then $0 never stalls
    cyc(0, 1, 8, 0, 0, 1, 8, 0, 0);
    idle(4);
    cyc(0, 1, 0, 0, 0, 1, 0, 0, 0);
    idle(1);
    // rt match only counts when rt is a source
    cyc(0, 1, 0, 9, 0, 1, 9, 0, 0);
    idle(4);
    cyc(0, 1, 0, 9, 1, 1, 9, 0, 0);
    idle(4);
    // branch beats hazard; branch aborts an ongoing stall
    cyc(0, 1, 8, 0, 0, 1, 8, 1, 0);
    idle(4);
    cyc(0, 1, 8, 0, 0, 1, 8, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(4);
    // saturation of the 4-bit counter, then clear beats increment
    repeat (20) cyc(0, 1, 8, 0, 0, 1, 8, 0, 0);
    idle(1);
    @(negedge clk);
    chk("sat_stall_cnt", int'(if2.stall_cnt), 15);
    cyc(0, 1, 8, 0, 0, 1, 8, 0, 1);
    idle(1);
    @(negedge clk);
    chk("clr_stall_cnt", int'(if2.stall_cnt), 0);
    idle(4);
    // randomized traffic on a small register set to make hazards common
    repeat (3000) begin
      cyc($urandom_range(0, 63) == 0,
          $urandom_range(0, 3) != 0,
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)),
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1,
          int'($urandom_range(0, 3)),
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 63) == 0);
    end
    idle(2);
    repeat (2) @(negedge clk);
    chk("queues_drained", q0.size() + q1.size() + q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
